instr_encoder: RTL and testbench

- Inverse of the immediate generator: packs opcode, register, function and 32-bit immediate fields into a 32-bit RV32I instruction word.
- The immediate is scattered into its I/S/B/U/J bit positions, and a range check flags immediates that the selected format cannot represent.
- 2-stage pipeline with valid/ready handshakes on both sides.
- Sits between the test-program generator / boot-ROM loader and instruction memory. Also used by the bench as a golden encoder.

---
 rtl/instr_encoder.sv | 191 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction packer with immediate range check
// and saturating delivered/error counters. Defining the macro
// INSTR_ENCODER_ROUNDTRIP_CHK_EN adds rt_mismatch_o, which decodes the packed
// immediate back and flags any difference from the requested value.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       fmt_i,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [31:0]      imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      instr_o,
    output logic             err_o,
`ifdef INSTR_ENCODER_ROUNDTRIP_CHK_EN
    output logic             rt_mismatch_o,
`endif
    output logic [CNT_W-1:0] enc_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_IS  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    fmt_e             in_fmt;
    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic             s1_adv, s2_adv, s1_load, s2_load, fire;
    fmt_e             s1_fmt_q;
    logic [6:0]       s1_op_q, s1_f7_q;
    logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]       s1_f3_q;
    logic [31:0]      s1_imm_q;
    logic             s1_err_q, range_err_d;
    logic [31:0]      instr_q, pack_d;
    logic             err_q;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;

    assign in_fmt  = fmt_e'(fmt_i);
    assign s2_adv  = !s2_v_q || out_ready_i;
    assign s1_adv  = !s1_v_q || s2_adv;
    assign s1_load = s1_adv && in_valid_i;
    assign s2_load = s2_adv && s1_v_q;
    assign fire    = s2_v_q && out_ready_i;
    assign s1_v_d  = s1_adv ? in_valid_i : s1_v_q;
    assign s2_v_d  = s2_adv ? s1_v_q : s2_v_q;

    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_v_q;
    assign instr_o     = instr_q;
    assign err_o       = err_q;
    assign enc_cnt_o   = enc_cnt_q;
    assign err_cnt_o   = err_cnt_q;

    // Flag immediates the requested format cannot hold (sign range, alignment, zero low bits).
    always_comb begin
        range_err_d = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: range_err_d = !(&imm_i[31:11] || !(|imm_i[31:11]));
            FMT_IS:       range_err_d = |imm_i[31:5];
            FMT_B:        range_err_d = !(&imm_i[31:12] || !(|imm_i[31:12])) || imm_i[0];
            FMT_J:        range_err_d = !(&imm_i[31:20] || !(|imm_i[31:20])) || imm_i[0];
            FMT_U:        range_err_d = |imm_i[11:0];
            FMT_RSV:      range_err_d = 1'b1;
            default:      range_err_d = 1'b0;
        endcase
    end

    // Start from the R layout, then let the immediate overwrite the fields the format reuses.
    always_comb begin
        pack_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        case (s1_fmt_q)
            FMT_I:  pack_d[31:20] = s1_imm_q[11:0];
            FMT_IS: pack_d[24:20] = s1_imm_q[4:0];
            FMT_S: begin
                pack_d[31:25] = s1_imm_q[11:5];
                pack_d[11:7]  = s1_imm_q[4:0];
            end
            FMT_B: begin
                pack_d[31:25] = {s1_imm_q[12], s1_imm_q[10:5]};
                pack_d[11:7]  = {s1_imm_q[4:1], s1_imm_q[11]};
            end
            FMT_U:  pack_d[31:12] = s1_imm_q[31:12];
            FMT_J:  pack_d[31:12] = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12]};
            default: ;
        endcase
    end

    // Saturating counters advance on each output transfer.
    always_comb begin
        enc_cnt_d = (fire && enc_cnt_q != '1) ? enc_cnt_q + CNT_W'(1) : enc_cnt_q;
        err_cnt_d = (fire && err_q && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    // Stage valids and counters; reset drops anything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // S1 captures the request and its range verdict when it can advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_fmt_q <= FMT_R;
            s1_op_q  <= '0;
            s1_rd_q  <= '0;
            s1_rs1_q <= '0;
            s1_rs2_q <= '0;
            s1_f3_q  <= '0;
            s1_f7_q  <= '0;
            s1_imm_q <= '0;
            s1_err_q <= 1'b0;
        end else if (s1_load) begin
            s1_fmt_q <= in_fmt;
            s1_op_q  <= opcode_i;
            s1_rd_q  <= rd_i;
            s1_rs1_q <= rs1_i;
            s1_rs2_q <= rs2_i;
            s1_f3_q  <= funct3_i;
            s1_f7_q  <= funct7_i;
            s1_imm_q <= imm_i;
            s1_err_q <= range_err_d;
        end
    end

    // S2 holds the packed word stable until downstream takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= '0;
            err_q   <= 1'b0;
        end else if (s2_load) begin
            instr_q <= pack_d;
            err_q   <= s1_err_q;
        end
    end

`ifdef INSTR_ENCODER_ROUNDTRIP_CHK_EN
    logic [31:0] dec_d;
    logic        rt_d, rt_q;

    assign rt_mismatch_o = rt_q;
    assign rt_d = (s1_fmt_q != FMT_R) && (s1_fmt_q != FMT_RSV) && (dec_d != s1_imm_q);

    // Standard RV32I immediate decode of the packed word; IS is zero-extended, R yields 0.
    always_comb begin
        dec_d = '0;
        case (s1_fmt_q)
            FMT_I:  dec_d = {{20{pack_d[31]}}, pack_d[31:20]};
            FMT_IS: dec_d = {27'd0, pack_d[24:20]};
            FMT_S:  dec_d = {{20{pack_d[31]}}, pack_d[31:25], pack_d[11:7]};
            FMT_B:  dec_d = {{19{pack_d[31]}}, pack_d[31], pack_d[7], pack_d[30:25], pack_d[11:8], 1'b0};
            FMT_U:  dec_d = {pack_d[31:12], 12'd0};
            FMT_J:  dec_d = {{11{pack_d[31]}}, pack_d[31], pack_d[19:12], pack_d[20], pack_d[30:21], 1'b0};
            default: dec_d = '0;
        endcase
    end

    // Mismatch flag travels with the packed word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rt_q <= 1'b0;
        end else if (s2_load) begin
            rt_q <= rt_d;
        end
    end
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder against an arithmetic reference model.
module tb_instr_encoder;
    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             in_valid_i, in_ready_o;
    logic [2:0]       fmt_i;
    logic [6:0]       opcode_i, funct7_i;
    logic [4:0]       rd_i, rs1_i, rs2_i;
    logic [2:0]       funct3_i;
    logic [31:0]      imm_i;
    logic             out_valid_o, out_ready_i;
    logic [31:0]      instr_o;
    logic             err_o;
    logic [CNT_W-1:0] enc_cnt_o, err_cnt_o;
`ifdef INSTR_ENCODER_ROUNDTRIP_CHK_EN
    logic             rt_mismatch_o;
`endif

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .fmt_i(fmt_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .instr_o(instr_o), .err_o(err_o),
`ifdef INSTR_ENCODER_ROUNDTRIP_CHK_EN
        .rt_mismatch_o(rt_mismatch_o),
`endif
        .enc_cnt_o(enc_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        rt;
        int          stamp;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, last_stall = -1;
    int          exp_enc = 0, exp_err = 0;
    logic        hold_v = 1'b0, was_rst = 1'b0, done;
    logic [31:0] held_instr;
    logic        held_err;

    always @(posedge clk_i) cyc++;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference: places each field by shift/mask and judges range with signed arithmetic.
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
        exp_t        e;
        int          s = signed'(imm);
        logic [31:0] o = 32'(op), d = 32'(rd) << 7, a = 32'(f3) << 12;
        logic [31:0] r1 = 32'(rs1) << 15, r2 = 32'(rs2) << 20, s7 = 32'(f7) << 25;
        case (f)
            3'd1: begin
                e.instr = o | d | a | r1 | (fld(imm, 11, 0) << 20);
                e.err = s < -2048 || s > 2047;
            end
            3'd2: begin
                e.instr = o | d | a | r1 | (fld(imm, 4, 0) << 20) | s7;
                e.err = imm >= 32'd32;
            end
            3'd3: begin
                e.instr = o | a | r1 | r2 | (fld(imm, 11, 5) << 25) | (fld(imm, 4, 0) << 7);
                e.err = s < -2048 || s > 2047;
            end
            3'd4: begin
                e.instr = o | a | r1 | r2 | (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25)
                        | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
                e.err = s < -4096 || s > 4095 || (s % 2) != 0;
            end
            3'd5: begin
                e.instr = o | d | (imm & 32'hFFFF_F000);
                e.err = (imm % 32'd4096) != 0;
            end
            3'd6: begin
                e.instr = o | d | (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21)
                        | (fld(imm, 11, 11) << 20) | (fld(imm, 19, 12) << 12);
                e.err = s < -1048576 || s > 1048575 || (s % 2) != 0;
            end
            default: begin
                e.instr = o | d | a | r1 | r2 | s7;
                e.err = (f == 3'd7);
            end
        endcase
        e.rt = (f == 3'd0 || f == 3'd7) ? 1'b0 : e.err;
        e.stamp = 0;
        return e;
    endfunction

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        exp_t e;
        int   n = 0;
        fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm; in_valid_i = 1'b1;
        @(negedge clk_i);
        while (!in_ready_o) begin
            n++;
            if (n > 200) begin
                $display("FAIL send_timeout in_ready_o stuck at 0 for %0d cycles", n);
                $fatal(1);
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        e = model(f, op, rd, rs1, rs2, f3, f7, imm);
        e.stamp = cyc;
        q.push_back(e);
        in_valid_i = 1'b0;
    endtask

    task automatic send_rand();
        int          bnd[14] = '{2047, 2048, -2048, -2049, 31, 32, 4094, 4095, -4096, -4098,
                                 1048574, 1048576, -1048576, -1048578};
        logic [31:0] imm;
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            2: imm = $urandom & 32'hFFFF_F000;
            default: imm = 32'(bnd[$urandom_range(0, 13)]);
        endcase
        send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), imm);
    endtask

    // Monitor: checks reset values, ready, counters, stability, latency and scoreboard order.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            chk("rst_out_valid", 32'(out_valid_o), 32'd0);
            chk("rst_instr", instr_o, 32'd0);
            chk("rst_err", 32'(err_o), 32'd0);
            chk("rst_enc_cnt", 32'(enc_cnt_o), 32'd0);
            chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
`ifdef INSTR_ENCODER_ROUNDTRIP_CHK_EN
            chk("rst_rt", 32'(rt_mismatch_o), 32'd0);
`endif
            q.delete();
            exp_enc = 0;
            exp_err = 0;
            hold_v = 1'b0;
            was_rst = 1'b1;
        end else begin
            if (was_rst) chk("ready_after_rst", 32'(in_ready_o), 32'd1);
            was_rst = 1'b0;
            chk("in_ready", 32'(in_ready_o), 32'(!(q.size() >= 2 && !out_ready_i)));
            chk("enc_cnt", 32'(enc_cnt_o), 32'(exp_enc));
            chk("err_cnt", 32'(err_cnt_o), 32'(exp_err));
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid_o), 32'd0);
            end else if (out_valid_o) begin
                e = q[0];
                if (hold_v) begin
                    chk("hold_instr", instr_o, held_instr);
                    chk("hold_err", 32'(err_o), 32'(held_err));
                end else if (last_stall < e.stamp) begin
                    chk("latency", 32'(cyc), 32'(e.stamp + 1));
                end else begin
                    chk("latency_min", 32'(cyc > e.stamp), 32'd1);
                end
                chk("instr", instr_o, e.instr);
                chk("err", 32'(err_o), 32'(e.err));
`ifdef INSTR_ENCODER_ROUNDTRIP_CHK_EN
                chk("rt_mismatch", 32'(rt_mismatch_o), 32'(e.rt));
`endif
                if (out_ready_i) begin
                    void'(q.pop_front());
                    if (exp_enc < 2**CNT_W - 1) exp_enc++;
                    if (e.err && exp_err < 2**CNT_W - 1) exp_err++;
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    held_instr = instr_o;
                    held_err = err_o;
                    last_stall = cyc;
                end
            end
        end
    end

    initial begin
        int n;
        rst_ni = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        fmt_i = '0; opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        funct3_i = '0; funct7_i = '0; imm_i = '0;
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        // Known encodings and range-error cases, unstalled.
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF);
        send(3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC);
        send(3'd2, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3);
        send(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000);
        send(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001);
        send(3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
        send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'd2048);
        send(3'd7, 7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 7'h01, 32'd0);
        repeat (3) begin @(posedge clk_i); #1; end
        // Backpressure: three back-to-back requests against a 5-cycle stall.
        out_ready_i = 1'b0;
        fork
            repeat (3) send_rand();
            begin repeat (5) begin @(posedge clk_i); #1; end out_ready_i = 1'b1; end
        join
        repeat (4) begin @(posedge clk_i); #1; end
        // Reset with two words held, then a fresh request.
        out_ready_i = 1'b0;
        send_rand();
        send_rand();
        repeat (2) begin @(posedge clk_i); #1; end
        rst_ni = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        send(3'd3, 7'h23, 5'd0, 5'd2, 5'd7, 3'd2, 7'h00, 32'hFFFF_F800);
        repeat (3) begin @(posedge clk_i); #1; end
        // Random traffic with random downstream backpressure.
        done = 1'b0;
        fork
            begin
                repeat (300) begin
                    send_rand();
                    repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
                end
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk_i);
                #1 out_ready_i = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready_i = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin @(negedge clk_i); n++; end
        @(posedge clk_i);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain %0d words never delivered", q.size());
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
